// File: rtl/des_la_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_la_sequencer_if : LA command bus and DES engine bus of the        |
// | sequencer. Rev 1.0                                                    |
// +----------------------------------------------------------------------+
interface des_la_sequencer_if;
   logic        la_stb;
   logic [2:0]  la_op;
   logic [63:0] la_word;
   logic        la_ack;
   logic [63:0] des_key;
   logic [63:0] des_din;
   logic        des_decrypt;
   logic        des_start;
   logic        des_done;
   logic [63:0] des_dout;
   logic [63:0] res_data;
   logic [15:0] status;

   // master: firmware plus DES engine side; slave: the sequencer
   modport master (
      output la_stb, la_op, la_word, des_done, des_dout,
      input  la_ack, des_key, des_din, des_decrypt, des_start, res_data, status
   );
   modport slave (
      input  la_stb, la_op, la_word, des_done, des_dout,
      output la_ack, des_key, des_din, des_decrypt, des_start, res_data, status
   );
endinterface
`default_nettype wire

// File: rtl/des_la_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_la_sequencer : LA-driven command sequencer for the DES engine     |
// | with one-deep command buffer and hung-engine timeout. Rev 1.0         |
// +----------------------------------------------------------------------+
module des_la_sequencer #(
   parameter int          TIMEOUT_CYCLES = 4096,
   parameter logic [7:0]  STATUS_BASE    = 8'hAB
) (
   input  logic                 clock,
   input  logic                 resetb,
   des_la_sequencer_if.slave    seq
);
   typedef enum logic [3:0] {
      ST_IDLE  = 4'h0,
      ST_START = 4'h1,
      ST_WAIT  = 4'h2,
      ST_ERROR = 4'hF
   } state_t;

   localparam logic [2:0] c_OP_NOP       = 3'd0;
   localparam logic [2:0] c_OP_LOAD_KEY  = 3'd1;
   localparam logic [2:0] c_OP_LOAD_DATA = 3'd2;
   localparam logic [2:0] c_OP_RUN_ENC   = 3'd3;
   localparam logic [2:0] c_OP_RUN_DEC   = 3'd4;
   localparam logic [2:0] c_OP_CLEAR     = 3'd5;

   localparam int              c_TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_TW-1:0] c_TCNT_MAX  = c_TW'(TIMEOUT_CYCLES - 1);

   state_t          r_state;
   logic            r_stb_q;
   logic            r_pend_v;
   logic [2:0]      r_pend_op;
   logic [63:0]     r_pend_word;
   logic            r_drop;
   logic [c_TW-1:0] r_tcnt;
   logic            r_ack;
   logic [63:0]     r_key;
   logic [63:0]     r_din;
   logic            r_decrypt;
   logic [63:0]     r_res;
   logic            r_key_ok;
   logic            r_data_ok;
   logic            r_res_valid;
   logic            r_err;

   logic            w_edge;
   logic            w_busy;
   logic            w_exec;
   logic [2:0]      w_op;
   logic [63:0]     w_word;
   logic            w_clear;

   assign w_edge  = seq.la_stb & ~r_stb_q;
   assign w_busy  = (r_state == ST_START) || (r_state == ST_WAIT);
   // A buffered command always takes priority over a fresh strobe in IDLE
   assign w_exec  = (r_state == ST_IDLE) && (r_pend_v || w_edge);
   assign w_op    = r_pend_v ? r_pend_op   : seq.la_op;
   assign w_word  = r_pend_v ? r_pend_word : seq.la_word;
   assign w_clear = (w_exec && (w_op == c_OP_CLEAR)) ||
                    ((r_state == ST_ERROR) && w_edge && (seq.la_op == c_OP_CLEAR));

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state     <= ST_IDLE;
         r_stb_q     <= 1'b0;
         r_pend_v    <= 1'b0;
         r_pend_op   <= 3'd0;
         r_pend_word <= 64'd0;
         r_drop      <= 1'b0;
         r_tcnt      <= '0;
         r_ack       <= 1'b0;
         r_key       <= 64'd0;
         r_din       <= 64'd0;
         r_decrypt   <= 1'b0;
         r_res       <= 64'd0;
         r_key_ok    <= 1'b0;
         r_data_ok   <= 1'b0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_stb_q <= seq.la_stb;

         // Strobes during a run are buffered; a second one is lost and poisons the run
         if (w_busy && w_edge) begin
            if (!r_pend_v) begin
               r_pend_v    <= 1'b1;
               r_pend_op   <= seq.la_op;
               r_pend_word <= seq.la_word;
            end else begin
               r_err  <= 1'b1;
               r_drop <= 1'b1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_exec) begin
                  r_ack    <= ~r_ack;
                  r_pend_v <= r_pend_v & w_edge;
                  if (r_pend_v && w_edge) begin
                     r_pend_op   <= seq.la_op;
                     r_pend_word <= seq.la_word;
                  end
                  case (w_op)
                     c_OP_NOP, c_OP_CLEAR: ;
                     c_OP_LOAD_KEY: begin
                        r_key    <= w_word;
                        r_key_ok <= 1'b1;
                     end
                     c_OP_LOAD_DATA: begin
                        r_din       <= w_word;
                        r_data_ok   <= 1'b1;
                        r_res_valid <= 1'b0;
                     end
                     c_OP_RUN_ENC, c_OP_RUN_DEC: begin
                        if (r_key_ok && r_data_ok) begin
                           r_decrypt   <= (w_op == c_OP_RUN_DEC);
                           r_res_valid <= 1'b0;
                           r_state     <= ST_START;
                        end else begin
                           r_err   <= 1'b1;
                           r_state <= ST_ERROR;
                        end
                     end
                     default: begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERROR;
                     end
                  endcase
               end
            end
            ST_START: begin
               r_tcnt  <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (seq.des_done) begin
                  r_res       <= seq.des_dout;
                  r_res_valid <= 1'b1;
                  if (r_drop || (w_edge && r_pend_v)) begin
                     r_pend_v <= 1'b0;
                     r_drop   <= 1'b0;
                     r_state  <= ST_ERROR;
                  end else begin
                     r_state  <= ST_IDLE;
                  end
               end else if (r_tcnt == c_TCNT_MAX) begin
                  r_err    <= 1'b1;
                  r_pend_v <= 1'b0;
                  r_drop   <= 1'b0;
                  r_state  <= ST_ERROR;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            ST_ERROR: begin
               r_pend_v <= 1'b0;
               r_drop   <= 1'b0;
               if (w_edge && (seq.la_op == c_OP_CLEAR)) begin
                  r_ack   <= ~r_ack;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_clear) begin
            r_key       <= 64'd0;
            r_din       <= 64'd0;
            r_res       <= 64'd0;
            r_key_ok    <= 1'b0;
            r_data_ok   <= 1'b0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
         end
      end
   end

   assign seq.la_ack      = r_ack;
   assign seq.des_key     = r_key;
   assign seq.des_din     = r_din;
   assign seq.des_decrypt = r_decrypt;
   assign seq.des_start   = (r_state == ST_START);
   assign seq.res_data    = r_res;
   assign seq.status      = {STATUS_BASE, r_err, r_res_valid, r_data_ok, r_key_ok, r_state};
endmodule
`default_nettype wire

// File: tb/tb_des_la_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_des_la_sequencer : scoreboard bench with a command-level model of  |
// | the sequencer and a behavioural DES engine. Rev 1.0                   |
// +----------------------------------------------------------------------+
module tb_des_la_sequencer;
   localparam int TO = 16;

   typedef struct {
      logic [15:0] status;
      logic [63:0] key;
      logic [63:0] din;
      int          op;
   } ack_exp_t;

   typedef struct {
      logic [15:0] status;
      logic [63:0] res;
      logic        dec;
      int          wait_cycles;
   } run_exp_t;

   logic clock = 1'b0;
   logic resetb;
   always #5 clock = ~clock;

   des_la_sequencer_if bus();

   des_la_sequencer #(.TIMEOUT_CYCLES(TO), .STATUS_BASE(8'hAB)) dut (
      .clock  (clock),
      .resetb (resetb),
      .seq    (bus)
   );

   ack_exp_t    ack_q[$];
   run_exp_t    run_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          ack_toggles = 0;
   int          exp_acks = 0;
   int          start_cnt = 0;
   int          exp_starts = 0;
   int          eng_delay = 1;
   logic [63:0] eng_dout = 64'd0;

   // command-level model of the sequencer
   bit          m_key_ok, m_data_ok, m_res_valid, m_err, m_in_err;
   logic [63:0] m_key, m_din, m_res;

   function automatic logic [15:0] m_status(input logic [3:0] st);
      return {8'hAB, m_err, m_res_valid, m_data_ok, m_key_ok, st};
   endfunction

   task automatic model_clear();
      m_key = 0; m_din = 0; m_res = 0;
      m_key_ok = 0; m_data_ok = 0; m_res_valid = 0; m_err = 0; m_in_err = 0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic strobe(input logic [2:0] op, input logic [63:0] w);
      bus.la_op = op; bus.la_word = w; bus.la_stb = 1'b1;
      tick();
      bus.la_stb = 1'b0;
      tick();
   endtask

   // Applies the command to the model, queues what the DUT must show, then strobes it
   task automatic issue(input logic [2:0] op, input logic [63:0] w, input bit drop);
      ack_exp_t ae;
      run_exp_t re;
      bit       acks = 1'b1;
      bit       is_run = 1'b0;
      logic [3:0] st = 4'h0;
      if (m_in_err) begin
         if (op == 3'd5) model_clear();
         else acks = 1'b0;
      end else begin
         case (op)
            3'd0: ;
            3'd1: begin m_key = w; m_key_ok = 1; end
            3'd2: begin m_din = w; m_data_ok = 1; m_res_valid = 0; end
            3'd3, 3'd4: begin
               if (m_key_ok && m_data_ok) begin
                  m_res_valid = 0; st = 4'h1; is_run = 1'b1;
               end else begin
                  m_err = 1; m_in_err = 1; st = 4'hF;
               end
            end
            3'd5: model_clear();
            default: begin m_err = 1; m_in_err = 1; st = 4'hF; end
         endcase
      end
      if (acks) begin
         ae.status = m_status(st); ae.key = m_key; ae.din = m_din; ae.op = int'(op);
         ack_q.push_back(ae);
         exp_acks++;
      end
      if (is_run) begin
         exp_starts++;
         re.dec = (op == 3'd4);
         if (eng_delay < 0) begin
            m_err = 1; m_in_err = 1;
            re.wait_cycles = TO;
            re.status = m_status(4'hF);
         end else begin
            m_res = eng_dout; m_res_valid = 1;
            re.wait_cycles = eng_delay;
            if (drop) begin
               m_err = 1; m_in_err = 1;
               re.status = m_status(4'hF);
            end else begin
               re.status = m_status(4'h0);
            end
         end
         re.res = m_res;
         run_q.push_back(re);
      end
      strobe(op, w);
   endtask

   task automatic settle();
      for (int i = 0; i < 100 && (ack_q.size() != 0 || run_q.size() != 0); i++) tick();
      if (ack_q.size() != 0 || run_q.size() != 0) begin
         n_checks++;
         $display("FAIL settle: %0d acks and %0d runs outstanding, expected none",
                  ack_q.size(), run_q.size());
         ack_q.delete();
         run_q.delete();
      end
      tick();
      tick();
   endtask

   // Behavioural engine: answers each start pulse after eng_delay cycles (never if negative)
   initial begin
      int d;
      bus.des_done = 1'b0;
      bus.des_dout = 64'd0;
      forever begin
         @(negedge clock);
         if (resetb && bus.des_start) begin
            start_cnt++;
            d = eng_delay;
            if (d > 0) begin
               repeat (d) @(negedge clock);
               bus.des_dout = eng_dout;
               bus.des_done = 1'b1;
               @(negedge clock);
               bus.des_done = 1'b0;
            end
         end
      end
   end

   // Monitor: pops on every ack toggle and on every exit from WAIT
   initial begin
      logic       prev_ack;
      logic [3:0] prev_st;
      int         wcnt;
      ack_exp_t   ae;
      run_exp_t   re;
      prev_ack = 1'b0; prev_st = 4'h0; wcnt = 0;
      forever begin
         @(negedge clock);
         if (!resetb) begin
            prev_ack = bus.la_ack;
            prev_st  = bus.status[3:0];
            wcnt     = 0;
         end else begin
            if (bus.la_ack !== prev_ack) begin
               ack_toggles++;
               if (ack_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_ack: la_ack toggled, status %h, expected no ack", bus.status);
               end else begin
                  ae = ack_q.pop_front();
                  chk($sformatf("ack_status_op%0d", ae.op), 64'(bus.status), 64'(ae.status));
                  chk($sformatf("ack_key_op%0d", ae.op), bus.des_key, ae.key);
                  chk($sformatf("ack_din_op%0d", ae.op), bus.des_din, ae.din);
               end
            end
            prev_ack = bus.la_ack;
            if (prev_st == 4'h2 && bus.status[3:0] != 4'h2) begin
               if (run_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_run_end: status %h, expected no run", bus.status);
               end else begin
                  re = run_q.pop_front();
                  chk("run_res_data", bus.res_data, re.res);
                  chk("run_status", 64'(bus.status), 64'(re.status));
                  chk("run_decrypt", 64'(bus.des_decrypt), 64'(re.dec));
                  chk("run_wait_cycles", 64'(wcnt), 64'(re.wait_cycles));
               end
            end
            wcnt    = (bus.status[3:0] == 4'h2) ? wcnt + 1 : 0;
            prev_st = bus.status[3:0];
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base_ack, base_start, op_sel;
      logic [2:0]  op;
      logic [63:0] w;
      resetb = 1'b0;
      bus.la_stb = 1'b0; bus.la_op = 3'd0; bus.la_word = 64'd0;
      model_clear();
      repeat (3) tick();
      chk("reset_status", 64'(bus.status), 64'h0000_0000_0000_AB00);
      chk("reset_ack", 64'(bus.la_ack), 64'd0);
      chk("reset_start", 64'(bus.des_start), 64'd0);
      resetb = 1'b1;
      tick();

      // encrypt flow with the classic DES vector
      base_ack = ack_toggles; base_start = start_cnt;
      issue(3'd1, 64'h133457799BBCDFF1, 1'b0); settle();
      issue(3'd2, 64'h0123456789ABCDEF, 1'b0); settle();
      eng_delay = 5; eng_dout = 64'h85E813540F0AB405;
      issue(3'd3, 64'd0, 1'b0); settle();
      chk("enc_status", 64'(bus.status), 64'h0000_0000_0000_AB70);
      chk("enc_res", bus.res_data, 64'h85E813540F0AB405);
      chk("enc_ack_toggles", 64'(ack_toggles - base_ack), 64'd3);
      chk("enc_starts", 64'(start_cnt - base_start), 64'd1);

      // run without a key, ERROR ignores everything but CLEAR
      issue(3'd5, 64'd0, 1'b0); settle();
      issue(3'd3, 64'd0, 1'b0); settle();
      issue(3'd1, 64'hDEADBEEFCAFEF00D, 1'b0); settle();
      chk("err_status_hold", 64'(bus.status), 64'h0000_0000_0000_AB8F);
      chk("err_key_hold", bus.des_key, 64'd0);
      issue(3'd5, 64'd0, 1'b0); settle();
      chk("clear_status", 64'(bus.status), 64'h0000_0000_0000_AB00);

      // hung engine times out
      issue(3'd1, {$urandom(), $urandom()}, 1'b0); settle();
      issue(3'd2, {$urandom(), $urandom()}, 1'b0); settle();
      eng_delay = -1;
      issue(3'd4, 64'd0, 1'b0); settle();
      issue(3'd5, 64'd0, 1'b0); settle();

      // one strobe during WAIT is buffered, a second one poisons the run
      issue(3'd1, {$urandom(), $urandom()}, 1'b0); settle();
      issue(3'd2, {$urandom(), $urandom()}, 1'b0); settle();
      eng_delay = 8; eng_dout = {$urandom(), $urandom()};
      issue(3'd3, 64'd0, 1'b0);
      tick(); tick();
      w = {$urandom(), $urandom()};
      issue(3'd2, w, 1'b0); settle();
      chk("pend_status", 64'(bus.status), 64'h0000_0000_0000_AB30);
      chk("pend_din", bus.des_din, w);
      eng_dout = {$urandom(), $urandom()};
      issue(3'd4, 64'd0, 1'b1);
      tick();
      strobe(3'd1, {$urandom(), $urandom()});
      strobe(3'd0, 64'd0);
      settle();
      chk("drop_status", 64'(bus.status), 64'h0000_0000_0000_ABFF);
      chk("drop_key_kept", bus.des_key, m_key);
      issue(3'd5, 64'd0, 1'b0); settle();

      // asynchronous reset in the middle of a run
      issue(3'd1, {$urandom(), $urandom()}, 1'b0); settle();
      issue(3'd2, {$urandom(), $urandom()}, 1'b0); settle();
      issue(3'd0, 64'd0, 1'b0); settle();
      eng_delay = 8; eng_dout = {$urandom(), $urandom()};
      issue(3'd3, 64'd0, 1'b0);
      tick(); tick();
      resetb = 1'b0;
      #1;
      chk("async_rst_status", 64'(bus.status), 64'h0000_0000_0000_AB00);
      chk("async_rst_start", 64'(bus.des_start), 64'd0);
      chk("async_rst_key", bus.des_key, 64'd0);
      ack_q.delete(); run_q.delete(); model_clear();
      base_start = start_cnt;
      tick(); tick();
      resetb = 1'b1;
      repeat (12) tick();
      chk("post_rst_status", 64'(bus.status), 64'h0000_0000_0000_AB00);
      chk("post_rst_res", bus.res_data, 64'd0);
      chk("post_rst_starts", 64'(start_cnt - base_start), 64'd0);

      // randomized command stream
      for (int n = 0; n < 120; n++) begin
         op_sel = int'($urandom_range(0, 9));
         case (op_sel)
            0: op = 3'd0;
            1, 2: op = 3'd1;
            3, 4: op = 3'd2;
            5, 9: op = 3'd3;
            6: op = 3'd4;
            7: op = 3'd5;
            default: op = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
         endcase
         if (m_in_err && $urandom_range(0, 1) == 0) op = 3'd5;
         if ($urandom_range(0, 9) == 0) eng_delay = -1;
         else eng_delay = int'($urandom_range(1, 8));
         eng_dout = {$urandom(), $urandom()};
         issue(op, {$urandom(), $urandom()}, 1'b0);
         settle();
      end

      chk("total_acks", 64'(ack_toggles), 64'(exp_acks));
      chk("total_starts", 64'(start_cnt), 64'(exp_starts));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
